sd_wb_sel_seq: RTL and testbench
================================

SD_WB_SEL_SEQ -- requirements
Module: sd_wb_sel_seq

Interface
- REQ-001 SHALL have parameter DATA_W, default 32, meaning Wishbone data width in bits (32, 64 or 128); BYTES = DATA_W/8, OFS_W = log2(BYTES).
- REQ-002 SHALL have parameter SIZE_W, default 24, meaning transfer-size width in bytes.
- REQ-003 SHALL have parameter BIG_ENDIAN, default 1, meaning 1 maps byte offset k to sel bit BYTES-1-k, and 0 maps it to sel bit k.
- REQ-004 wb_clk  input  1  sole clock, rising edge.
- REQ-005 rst_n  input  1  reset; one clock, reset is asynchronous and active-low.
- REQ-006 ena  input  1  transfer enable; low aborts.
- REQ-007 start  input  1  single-cycle request to latch base_adr_i and xfersize.
- REQ-008 base_adr_i  input  32  byte start address, any alignment.
- REQ-009 xfersize  input  SIZE_W  transfer length in bytes.
- REQ-010 beat_ack  input  1  current beat accepted (wbm ack).
- REQ-011 adr_o  output  32  BYTES-aligned beat address.
- REQ-012 sel_o  output  BYTES  byte-lane select for current beat.
- REQ-013 last_o  output  1  current beat is final.
- REQ-014 busy_o  output  1  state is RUN.
- REQ-015 done_o  output  1  one-cycle completion pulse.

Function
- REQ-016 SHALL implement states IDLE, RUN, DONE.
- REQ-017 IDLE: on start=1 and ena=1, SHALL latch ofs=base_adr_i[OFS_W-1:0], adr_o=base_adr_i with low OFS_W bits cleared, and left=xfersize; go to RUN if xfersize!=0, else to DONE.
- REQ-018 RUN first beat SHALL assert lanes ofs .. min(BYTES, ofs+left)-1; later beats SHALL assert lanes 0 .. min(BYTES, left)-1; lane-to-bit mapping per BIG_ENDIAN.
- REQ-019 sel_o, adr_o and last_o SHALL be valid the cycle after start and SHALL be held stable until beat_ack.
- REQ-020 On beat_ack in RUN, SHALL subtract the beat's byte count from left, add BYTES to adr_o, and clear the first-beat flag.
- REQ-021 last_o SHALL be 1 in RUN when the remaining bytes fit in the current beat; beat_ack with last_o=1 SHALL go to DONE.
- REQ-022 DONE SHALL assert done_o for exactly one cycle, then return to IDLE.
- REQ-023 In IDLE and DONE, sel_o SHALL be all ones and last_o 0.
- REQ-024 ena=0 in any state SHALL force IDLE on the next edge with no done_o pulse; ena=0 takes priority over start and beat_ack.
- REQ-025 start while in RUN or DONE SHALL be ignored.
- REQ-026 beat_ack outside RUN SHALL be ignored.
- REQ-027 left arithmetic SHALL be SIZE_W bits wide and never underflow; adr_o SHALL wrap modulo 2^32.

Reset
- REQ-028 rst_n=0 SHALL immediately force IDLE, adr_o=0, sel_o=all ones, last_o=0, busy_o=0, done_o=0, left=0, including mid-transfer.

Configuration
- REQ-029 Macro SD_WB_SEL_OVERRUN_EN: when defined, SHALL add output overrun_o (1 bit), set sticky by beat_ack outside RUN and cleared by reset or by an accepted start; when undefined, the port and its logic SHALL be absent and behaviour is otherwise identical.

Verification
- REQ-030 DATA_W=32, BIG_ENDIAN=1, start base 11 size 2 -> beat 1 adr 8 sel 4'h1; beat 2 adr 12 sel 4'h8 last_o=1; then done_o for 1 cycle and sel 4'hf.
- REQ-031 DATA_W=64, base 5 size 12 -> sel 8'h07, then 8'hFF, then 8'h80 with last_o=1; adr_o 0, 8, 16.
- REQ-032 DATA_W=32, BIG_ENDIAN=0, base 1 size 5 -> sel 4'hE, then 4'h3 with last_o=1.
- REQ-033 size 0 start -> no RUN cycle, done_o pulse next cycle, sel 4'hf throughout.
- REQ-034 ena dropped during beat 2 of a 19-byte aligned transfer -> IDLE next edge, no done_o; rst_n pulsed mid-RUN -> all outputs at reset values immediately.
- REQ-035 With SD_WB_SEL_OVERRUN_EN, beat_ack in IDLE -> overrun_o=1 held until the next accepted start.

Source files
------------

// File: rtl/sd_wb_sel_seq.sv
// Wishbone byte-lane sequencer: splits a byte-addressed transfer into aligned beats with sel_o lanes.
// Latency: beat outputs valid the cycle after start; done_o pulses the cycle after the final beat_ack.
// Backpressure: each beat is held until beat_ack; ena=0 aborts. Option SD_WB_SEL_OVERRUN_EN adds overrun_o.
module sd_wb_sel_seq #(
    parameter int DATA_W     = 32,
    parameter int SIZE_W     = 24,
    parameter int BIG_ENDIAN = 1
) (
    input  logic                  wb_clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic                  start,
    input  logic [31:0]           base_adr_i,
    input  logic [SIZE_W-1:0]     xfersize,
    input  logic                  beat_ack,
    output logic [31:0]           adr_o,
    output logic [DATA_W/8-1:0]   sel_o,
    output logic                  last_o,
    output logic                  busy_o,
    output logic                  done_o
`ifdef SD_WB_SEL_OVERRUN_EN
    ,
    output logic                  overrun_o
`endif
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFS_W = $clog2(BYTES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [OFS_W-1:0]    ofs;
    logic [SIZE_W-1:0]   left;
    logic                first;
    logic [31:0]         adr;

    logic [SIZE_W-1:0]   room;
    logic [SIZE_W-1:0]   beat_bytes;
    logic                fits;
    logic [OFS_W-1:0]    lo;
    logic [BYTES-1:0]    lane_sel;
    logic                load;
    logic                step;

    assign load = ena && start && (state == IDLE);
    assign step = ena && beat_ack && (state == RUN);

    // Bytes this beat can carry: the first beat starts mid-word at ofs.
    always_comb begin
        room       = first ? (SIZE_W'(BYTES) - SIZE_W'(ofs)) : SIZE_W'(BYTES);
        beat_bytes = (left < room) ? left : room;
        fits       = (left <= room);
        lo         = first ? ofs : '0;
        lane_sel   = '0;
        for (int k = 0; k < BYTES; k++) begin
            if ((OFS_W'(k) >= lo) && ((SIZE_W'(k) - SIZE_W'(lo)) < beat_bytes)) begin
                if (BIG_ENDIAN != 0) begin
                    lane_sel[BYTES-1-k] = 1'b1;
                end else begin
                    lane_sel[k] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        adr_o     = adr;
        sel_o     = '1;
        last_o    = 1'b0;
        busy_o    = 1'b0;
        done_o    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (xfersize != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                sel_o  = lane_sel;
                last_o = fits;
                busy_o = 1'b1;
                if (beat_ack && fits) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done_o    = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (!ena) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge wb_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ofs   <= '0;
            left  <= '0;
            first <= 1'b0;
            adr   <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                ofs   <= base_adr_i[OFS_W-1:0];
                adr   <= {base_adr_i[31:OFS_W], {OFS_W{1'b0}}};
                left  <= xfersize;
                first <= 1'b1;
            end else if (step) begin
                left  <= left - beat_bytes;
                adr   <= adr + 32'(BYTES);
                first <= 1'b0;
            end
        end
    end

`ifdef SD_WB_SEL_OVERRUN_EN
    // Sticky: a stray ack outside RUN means the bus and sequencer disagree.
    always_ff @(posedge wb_clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_o <= 1'b0;
        end else if (load) begin
            overrun_o <= 1'b0;
        end else if (beat_ack && (state != RUN)) begin
            overrun_o <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sd_wb_sel_seq.sv
// Bench for sd_wb_sel_seq: three parameterisations checked against a byte-range reference model.
module tb_sd_wb_sel_seq;

    logic        clk;
    logic        rst_n;
    logic        ena   [3];
    logic        start [3];
    logic        ack   [3];
    logic [31:0] base  [3];
    logic [23:0] size  [3];

    logic [31:0] adr0, adr1, adr2;
    logic [3:0]  sel0;
    logic [7:0]  sel1;
    logic [3:0]  sel2;
    logic        last_v [3];
    logic        busy_v [3];
    logic        done_v [3];
`ifdef SD_WB_SEL_OVERRUN_EN
    logic        ovr_v  [3];
`endif

    int checks   = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sd_wb_sel_seq u0 (
        .wb_clk(clk), .rst_n(rst_n), .ena(ena[0]), .start(start[0]), .base_adr_i(base[0]),
        .xfersize(size[0]), .beat_ack(ack[0]), .adr_o(adr0), .sel_o(sel0), .last_o(last_v[0]),
        .busy_o(busy_v[0]), .done_o(done_v[0])
`ifdef SD_WB_SEL_OVERRUN_EN
        , .overrun_o(ovr_v[0])
`endif
    );

    sd_wb_sel_seq #(.DATA_W(64)) u1 (
        .wb_clk(clk), .rst_n(rst_n), .ena(ena[1]), .start(start[1]), .base_adr_i(base[1]),
        .xfersize(size[1]), .beat_ack(ack[1]), .adr_o(adr1), .sel_o(sel1), .last_o(last_v[1]),
        .busy_o(busy_v[1]), .done_o(done_v[1])
`ifdef SD_WB_SEL_OVERRUN_EN
        , .overrun_o(ovr_v[1])
`endif
    );

    sd_wb_sel_seq #(.BIG_ENDIAN(0)) u2 (
        .wb_clk(clk), .rst_n(rst_n), .ena(ena[2]), .start(start[2]), .base_adr_i(base[2]),
        .xfersize(size[2]), .beat_ack(ack[2]), .adr_o(adr2), .sel_o(sel2), .last_o(last_v[2]),
        .busy_o(busy_v[2]), .done_o(done_v[2])
`ifdef SD_WB_SEL_OVERRUN_EN
        , .overrun_o(ovr_v[2])
`endif
    );

    function automatic int nb(input int id);
        return (id == 1) ? 8 : 4;
    endfunction

    function automatic bit is_be(input int id);
        return id != 2;
    endfunction

    function automatic logic [15:0] ones(input int id);
        return (nb(id) == 8) ? 16'h00ff : 16'h000f;
    endfunction

    function automatic logic [15:0] sel_v(input int id);
        case (id)
            0:       return {12'b0, sel0};
            1:       return {8'b0, sel1};
            default: return {12'b0, sel2};
        endcase
    endfunction

    function automatic logic [31:0] adr_v(input int id);
        case (id)
            0:       return adr0;
            1:       return adr1;
            default: return adr2;
        endcase
    endfunction

    // Lane k of the beat at address a is selected iff byte a+k lies inside [b, e).
    function automatic logic [15:0] exp_sel(input int id, input logic [63:0] b,
                                            input logic [63:0] e, input logic [63:0] a);
        logic [15:0] s;
        logic [63:0] addr;
        s = '0;
        for (int k = 0; k < nb(id); k++) begin
            addr = a + 64'(k);
            if (addr >= b && addr < e) begin
                if (is_be(id)) s[nb(id)-1-k] = 1'b1;
                else           s[k] = 1'b1;
            end
        end
        return s;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input int id, input string tag, input logic exp_done);
        chk($sformatf("%s_sel%0d", tag, id), 64'(sel_v(id)), 64'(ones(id)));
        chk($sformatf("%s_last%0d", tag, id), 64'(last_v[id]), 64'd0);
        chk($sformatf("%s_busy%0d", tag, id), 64'(busy_v[id]), 64'd0);
        chk($sformatf("%s_done%0d", tag, id), 64'(done_v[id]), 64'(exp_done));
    endtask

    task automatic chk_reset_vals(input string tag);
        for (int id = 0; id < 3; id++) begin
            chk($sformatf("%s_adr%0d", tag, id), 64'(adr_v(id)), 64'd0);
            chk_quiet(id, tag, 1'b0);
        end
    endtask

    // Full transfer; noise drives ignored start pulses while a beat waits for ack.
    task automatic xfer(input int id, input logic [31:0] b, input int sz, input bit noise);
        logic [63:0] bb, e, a, bytes;
        bit          fin;
        int          gap;
        bytes = 64'(nb(id));
        bb    = {32'b0, b};
        e     = bb + 64'(sz);
        a     = bb & ~(bytes - 64'd1);
        @(negedge clk);
        start[id] = 1'b1;
        base[id]  = b;
        size[id]  = 24'(sz);
        @(negedge clk);
        start[id] = 1'b0;
        base[id]  = $urandom;
        size[id]  = 24'($urandom);
        fin = (sz == 0);
        for (int beat = 0; beat < 64 && !fin; beat++) begin
            gap = $urandom_range(0, 2);
            for (int g = 0; g <= gap; g++) begin
                chk($sformatf("x%0d_adr_b%0d", id, beat), 64'(adr_v(id)), 64'(a[31:0]));
                chk($sformatf("x%0d_sel_b%0d", id, beat), 64'(sel_v(id)), 64'(exp_sel(id, bb, e, a)));
                chk($sformatf("x%0d_last_b%0d", id, beat), 64'(last_v[id]), 64'(e <= a + bytes));
                chk($sformatf("x%0d_busy_b%0d", id, beat), 64'(busy_v[id]), 64'd1);
                chk($sformatf("x%0d_done_b%0d", id, beat), 64'(done_v[id]), 64'd0);
                if (g == gap) begin
                    ack[id] = 1'b1;
                end else if (noise) begin
                    start[id] = 1'b1;
                    base[id]  = $urandom;
                end
                @(negedge clk);
                ack[id]   = 1'b0;
                start[id] = 1'b0;
            end
            fin = (e <= a + bytes);
            a   = a + bytes;
        end
        chk_quiet(id, "xend", 1'b1);
        @(negedge clk);
        chk_quiet(id, "xpost", 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ena[i] = 1'b1; start[i] = 1'b0; ack[i] = 1'b0; base[i] = '0; size[i] = '0;
        end
        #3;
        chk_reset_vals("rst");
`ifdef SD_WB_SEL_OVERRUN_EN
        chk("ovr_rst", 64'(ovr_v[0]), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_quiet(0, "idle", 1'b0);

        // Directed cases from the datasheet examples.
        xfer(0, 32'd11, 2, 1'b0);
        xfer(1, 32'd5, 12, 1'b0);
        xfer(2, 32'd1, 5, 1'b0);
        xfer(0, 32'd0, 0, 1'b0);
        xfer(0, 32'hFFFF_FFFE, 6, 1'b0);
        xfer(1, 32'd3, 30, 1'b1);

        // Ack in IDLE ignored; start with ena low ignored.
        @(negedge clk);
        ack[0] = 1'b1;
        @(negedge clk);
        ack[0] = 1'b0;
        chk_quiet(0, "ackidle", 1'b0);
`ifdef SD_WB_SEL_OVERRUN_EN
        chk("ovr_set", 64'(ovr_v[0]), 64'd1);
        @(negedge clk);
        @(negedge clk);
        chk("ovr_hold", 64'(ovr_v[0]), 64'd1);
`endif
        ena[0] = 1'b0; start[0] = 1'b1; size[0] = 24'd5;
        @(negedge clk);
        ena[0] = 1'b1; start[0] = 1'b0;
        chk_quiet(0, "enastart", 1'b0);

        // Abort in beat 2 of a 19-byte aligned transfer; ack same cycle must lose to ena.
        start[0] = 1'b1; base[0] = 32'd0; size[0] = 24'd19;
        @(negedge clk);
        start[0] = 1'b0;
`ifdef SD_WB_SEL_OVERRUN_EN
        chk("ovr_clr", 64'(ovr_v[0]), 64'd0);
`endif
        chk("ab_b1_sel", 64'(sel_v(0)), 64'hf);
        ack[0] = 1'b1;
        @(negedge clk);
        ack[0] = 1'b0;
        chk("ab_b2_adr", 64'(adr_v(0)), 64'd4);
        chk("ab_b2_busy", 64'(busy_v[0]), 64'd1);
        ena[0] = 1'b0; ack[0] = 1'b1;
        @(negedge clk);
        ena[0] = 1'b1; ack[0] = 1'b0;
        chk_quiet(0, "abort", 1'b0);
        @(negedge clk);
        chk_quiet(0, "abort2", 1'b0);

        // Asynchronous reset in the middle of a RUN, checked before any clock edge.
        start[1] = 1'b1; base[1] = 32'd0; size[1] = 24'd40;
        @(negedge clk);
        start[1] = 1'b0;
        ack[1] = 1'b1;
        @(negedge clk);
        ack[1] = 1'b0;
        chk("mr_adr", 64'(adr_v(1)), 64'd8);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk_quiet(1, "postrst", 1'b0);

        for (int n = 0; n < 12; n++) begin
            for (int id = 0; id < 3; id++) begin
                xfer(id, $urandom, int'($urandom_range(0, 40)), 1'($urandom_range(0, 1)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
